// File: rtl/parking_gate_arbiter.sv
// Single-lane parking gate arbiter: grants the shared lane to entry or exit,
// keeps a saturating occupancy count and flags timeouts and count errors.
module parking_gate_arbiter #(
    parameter int CAPACITY     = 25,
    parameter int OCC_W        = 5,
    parameter int TIMEOUT      = 500000000,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             ENTER_REQ,
    input  logic             EXIT_REQ,
    input  logic             ENTER,
    input  logic             EXIT,
    output logic             GRANT_IN,
    output logic             GRANT_OUT,
    output logic [OCC_W-1:0] OCCUPANCY,
    output logic             FULL,
    output logic             EMPTY,
    output logic             TIMEOUT_ERR,
    output logic             COUNT_ERR
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [OCC_W-1:0] OCC_CAP  = OCC_W'(CAPACITY);

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IN_S,
        GRANT_OUT_S,
        CLEAR
    } state_t;

    state_t           state;
    logic             last_dir;
    logic [TMR_W-1:0] grant_tmr;
    logic [CLR_W-1:0] clear_cnt;

    logic             eligible_in;
    logic             eligible_out;
    logic [OCC_W-1:0] occ_next;
    logic             count_err_next;

    // Saturating count step; returns {error, next_count}.
    function automatic logic [OCC_W:0] occ_step(input logic [OCC_W-1:0] occ,
                                                input logic             inc,
                                                input logic             dec);
        logic [OCC_W:0] res;
        res = {1'b0, occ};
        if (inc && !dec) begin
            if (occ == OCC_CAP) res = {1'b1, occ};
            else                res = {1'b0, occ + OCC_W'(1)};
        end else if (dec && !inc) begin
            if (occ == '0) res = {1'b1, occ};
            else           res = {1'b0, occ - OCC_W'(1)};
        end
        return res;
    endfunction

    assign eligible_in  = ENTER_REQ && !FULL;
    assign eligible_out = EXIT_REQ && !EMPTY;

    always_comb begin
        {count_err_next, occ_next} = occ_step(OCCUPANCY, ENTER, EXIT);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= IDLE;
            last_dir    <= DIR_OUT;
            grant_tmr   <= '0;
            clear_cnt   <= '0;
            OCCUPANCY   <= '0;
            FULL        <= 1'b0;
            EMPTY       <= 1'b1;
            GRANT_IN    <= 1'b0;
            GRANT_OUT   <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            COUNT_ERR   <= 1'b0;
        end else begin
            // Sensors reflect physical truth, so the count follows them in every state.
            OCCUPANCY   <= occ_next;
            FULL        <= (occ_next == OCC_CAP);
            EMPTY       <= (occ_next == '0);
            COUNT_ERR   <= count_err_next;
            TIMEOUT_ERR <= 1'b0;
            GRANT_IN    <= 1'b0;
            GRANT_OUT   <= 1'b0;

            case (state)
                IDLE: begin
                    grant_tmr <= '0;
                    clear_cnt <= '0;
                    if (eligible_in && (!eligible_out || last_dir == DIR_OUT)) begin
                        state    <= GRANT_IN_S;
                        GRANT_IN <= 1'b1;
                        last_dir <= DIR_IN;
                    end else if (eligible_out) begin
                        state     <= GRANT_OUT_S;
                        GRANT_OUT <= 1'b1;
                        last_dir  <= DIR_OUT;
                    end
                end

                GRANT_IN_S: begin
                    clear_cnt <= '0;
                    if (ENTER) begin
                        state <= CLEAR;
                    end else if (grant_tmr == TMR_LAST) begin
                        state       <= CLEAR;
                        TIMEOUT_ERR <= 1'b1;
                    end else begin
                        grant_tmr <= grant_tmr + TMR_W'(1);
                        GRANT_IN  <= 1'b1;
                    end
                end

                GRANT_OUT_S: begin
                    clear_cnt <= '0;
                    if (EXIT) begin
                        state <= CLEAR;
                    end else if (grant_tmr == TMR_LAST) begin
                        state       <= CLEAR;
                        TIMEOUT_ERR <= 1'b1;
                    end else begin
                        grant_tmr <= grant_tmr + TMR_W'(1);
                        GRANT_OUT <= 1'b1;
                    end
                end

                CLEAR: begin
                    if (clear_cnt == CLR_LAST) state <= IDLE;
                    else                       clear_cnt <= clear_cnt + CLR_W'(1);
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with CAPACITY=3, TIMEOUT=8, CLEAR_CYCLES=2.
module tb_parking_gate_arbiter;

    localparam int CAP   = 3;
    localparam int OCC_W = 2;

    logic             CLOCK_50 = 1'b0;
    logic             RESET    = 1'b1;
    logic             ENTER_REQ = 1'b0;
    logic             EXIT_REQ  = 1'b0;
    logic             ENTER     = 1'b0;
    logic             EXIT      = 1'b0;
    logic             GRANT_IN;
    logic             GRANT_OUT;
    logic [OCC_W-1:0] OCCUPANCY;
    logic             FULL;
    logic             EMPTY;
    logic             TIMEOUT_ERR;
    logic             COUNT_ERR;

    parking_gate_arbiter #(
        .CAPACITY    (CAP),
        .OCC_W       (OCC_W),
        .TIMEOUT     (8),
        .CLEAR_CYCLES(2)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .ENTER_REQ  (ENTER_REQ),
        .EXIT_REQ   (EXIT_REQ),
        .ENTER      (ENTER),
        .EXIT       (EXIT),
        .GRANT_IN   (GRANT_IN),
        .GRANT_OUT  (GRANT_OUT),
        .OCCUPANCY  (OCCUPANCY),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .TIMEOUT_ERR(TIMEOUT_ERR),
        .COUNT_ERR  (COUNT_ERR)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        string tag;
        logic  gin;
        logic  gout;
        int    occ;
        logic  terr;
        logic  cerr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("%s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".grant_in"},  32'(GRANT_IN),    32'(e.gin));
        chk({e.tag, ".grant_out"}, 32'(GRANT_OUT),   32'(e.gout));
        chk({e.tag, ".occupancy"}, 32'(OCCUPANCY),   32'(e.occ));
        chk({e.tag, ".full"},      32'(FULL),        32'(e.occ == CAP));
        chk({e.tag, ".empty"},     32'(EMPTY),       32'(e.occ == 0));
        chk({e.tag, ".timeout"},   32'(TIMEOUT_ERR), 32'(e.terr));
        chk({e.tag, ".count_err"}, 32'(COUNT_ERR),   32'(e.cerr));
    endtask

    // Drive one cycle of inputs, queue what must appear after the edge, then compare.
    task automatic step(input string tag,
                        input logic rst, input logic ereq, input logic xreq,
                        input logic en, input logic ex,
                        input logic e_gin, input logic e_gout, input int e_occ,
                        input logic e_terr, input logic e_cerr);
        exp_t e;
        RESET     = rst;
        ENTER_REQ = ereq;
        EXIT_REQ  = xreq;
        ENTER     = en;
        EXIT      = ex;
        e.tag  = tag;
        e.gin  = e_gin;
        e.gout = e_gout;
        e.occ  = e_occ;
        e.terr = e_terr;
        e.cerr = e_cerr;
        sb.push_back(e);
        @(posedge CLOCK_50);
        #1;
        check_out();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single entry with completion three cycles after the grant.
        step("a_grant", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        step("a_hold1", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        step("a_hold2", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        step("a_enter", 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        step("a_clr1",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("a_clr2",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("a_idle",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Alternating ties from reset with one car inside.
        step("b_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("b_occ1",     0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        step("b_tie1",     0, 1, 1, 0, 0, 1, 0, 1, 0, 0);
        step("b_in_done",  0, 1, 1, 1, 0, 0, 0, 2, 0, 0);
        step("b_clr1",     0, 1, 1, 0, 0, 0, 0, 2, 0, 0);
        step("b_clr2",     0, 1, 1, 0, 0, 0, 0, 2, 0, 0);
        step("b_tie2",     0, 1, 1, 0, 0, 0, 1, 2, 0, 0);
        step("b_out_done", 0, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        step("b_clr3",     0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        step("b_clr4",     0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        step("b_tie3",     0, 1, 1, 0, 0, 1, 0, 1, 0, 0);
        step("b_in_done2", 0, 1, 1, 1, 0, 0, 0, 2, 0, 0);
        step("b_clr5",     0, 1, 1, 0, 0, 0, 0, 2, 0, 0);
        step("b_clr6",     0, 1, 1, 0, 0, 0, 0, 2, 0, 0);
        step("b_tie4",     0, 1, 1, 0, 0, 0, 1, 2, 0, 0);
        step("b_out_done2",0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        step("b_clr7",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("b_clr8",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Full lot blocks entry, exit still served, saturation at capacity.
        step("c_en1",       0, 0, 0, 1, 0, 0, 0, 2, 0, 0);
        step("c_en2",       0, 0, 0, 1, 0, 0, 0, 3, 0, 0);
        step("c_full_req",  0, 1, 0, 0, 0, 0, 0, 3, 0, 0);
        step("c_full_cerr", 0, 1, 0, 1, 0, 0, 0, 3, 0, 1);
        step("c_full_req2", 0, 1, 0, 0, 0, 0, 0, 3, 0, 0);
        step("c_out_grant", 0, 1, 1, 0, 0, 0, 1, 3, 0, 0);
        step("c_out_done",  0, 0, 0, 0, 1, 0, 0, 2, 0, 0);
        step("c_clr1",      0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        step("c_clr2",      0, 0, 0, 0, 0, 0, 0, 2, 0, 0);

        // Exit grant expires: eight grant cycles then one timeout pulse.
        step("d_grant", 0, 0, 1, 0, 0, 0, 1, 2, 0, 0);
        for (int i = 0; i < 7; i++)
            step($sformatf("d_hold%0d", i), 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        step("d_timeout", 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
        step("d_clr1",    0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        step("d_clr2",    0, 0, 0, 0, 0, 0, 0, 2, 0, 0);

        // Simultaneous pulses cancel; underflow at zero flags an error.
        step("e_both",     0, 0, 0, 1, 1, 0, 0, 2, 0, 0);
        step("e_ex1",      0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        step("e_ex2",      0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("e_ex_empty", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        step("e_quiet",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Completion on the last timer cycle wins over timeout.
        step("f_grant", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            step($sformatf("f_hold%0d", i), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("f_late_done", 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        step("f_clr1",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("f_clr2",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Wrong-direction pulse counts but keeps the grant; counting continues in CLEAR.
        step("g_grant", 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        step("g_wrong", 0, 0, 0, 1, 0, 0, 1, 2, 0, 0);
        step("g_done",  0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        step("g_clr1",  0, 0, 0, 1, 0, 0, 0, 2, 0, 0);
        step("g_clr2",  0, 0, 0, 0, 0, 0, 0, 2, 0, 0);

        // Reset mid-grant wins over a pending completion and restores tie priority.
        step("h_grant", 0, 1, 0, 0, 0, 1, 0, 2, 0, 0);
        step("h_reset", 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step("h_occ1",  0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        step("h_tie",   0, 1, 1, 0, 0, 1, 0, 1, 0, 0);

        ENTER_REQ = 1'b0;
        EXIT_REQ  = 1'b0;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameter CAPACITY, default 25, maximum number of cars in the lot.
REQ-002 Parameter OCC_W, default 5, width of the OCCUPANCY output; it SHALL satisfy 2**OCC_W > CAPACITY.
REQ-003 Parameter TIMEOUT, default 500000000, cycles a grant SHALL stay open without completion.
REQ-004 Parameter CLEAR_CYCLES, default 4, cycles the gate SHALL stay closed after each grant.
REQ-005 CLOCK_50  input  1  sole clock, all state updates on its rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 ENTER_REQ  input  1  level, car waiting at the entry side of the shared single lane.
REQ-008 EXIT_REQ  input  1  level, car waiting at the exit side of the shared single lane.
REQ-009 ENTER  input  1  one-cycle pulse from the sensor FSM, car completely entered.
REQ-010 EXIT  input  1  one-cycle pulse from the sensor FSM, car completely exited.
REQ-011 GRANT_IN  output  1  registered, lane granted to the entering direction.
REQ-012 GRANT_OUT  output  1  registered, lane granted to the exiting direction.
REQ-013 OCCUPANCY  output  OCC_W  registered, current car count.
REQ-014 FULL  output  1  registered, OCCUPANCY == CAPACITY.
REQ-015 EMPTY  output  1  registered, OCCUPANCY == 0.
REQ-016 TIMEOUT_ERR  output  1  registered one-cycle pulse, grant expired without completion.
REQ-017 COUNT_ERR  output  1  registered one-cycle pulse, ENTER while FULL or EXIT while EMPTY.

Function
REQ-018 The FSM SHALL have states IDLE, GRANT_IN_S, GRANT_OUT_S, CLEAR.
REQ-019 In IDLE: eligible_in = ENTER_REQ && !FULL; eligible_out = EXIT_REQ && !EMPTY.
REQ-020 In IDLE with exactly one eligible direction, the FSM SHALL move to that grant state on the next edge.
REQ-021 In IDLE with both directions eligible, the FSM SHALL grant the direction opposite to last_dir.
REQ-022 last_dir SHALL update on every grant and SHALL reset to EXIT, so that the first tie goes to entry.
REQ-023 GRANT_IN SHALL be high exactly in GRANT_IN_S, and GRANT_OUT exactly in GRANT_OUT_S; they SHALL never be high together.
REQ-024 Latency: an eligible request sampled in IDLE at edge N SHALL give a grant output high after edge N+1.
REQ-025 GRANT_IN_S SHALL go to CLEAR on an ENTER pulse; GRANT_OUT_S SHALL go to CLEAR on an EXIT pulse.
REQ-026 A grant timer SHALL clear on grant entry and increment every cycle in a grant state.
REQ-027 On reaching TIMEOUT-1 without completion, the FSM SHALL go to CLEAR and pulse TIMEOUT_ERR on that same transition.
REQ-028 Completion and timeout in the same cycle SHALL count as completion, with no TIMEOUT_ERR.
REQ-029 Deassertion of a request during a grant SHALL NOT end the grant; only completion or timeout ends it.
REQ-030 CLEAR SHALL last exactly CLEAR_CYCLES cycles with both grants low, then return to IDLE; requests are ignored during CLEAR.
REQ-031 OCCUPANCY SHALL update on every ENTER/EXIT pulse in any state, because the sensors reflect physical truth.
REQ-032 ENTER alone SHALL add 1 and EXIT alone SHALL subtract 1; ENTER and EXIT together SHALL leave OCCUPANCY unchanged with no error.
REQ-033 OCCUPANCY SHALL saturate: ENTER alone at CAPACITY or EXIT alone at 0 SHALL leave it unchanged and pulse COUNT_ERR.
REQ-034 FULL and EMPTY SHALL be registered from the next OCCUPANCY value, so they track OCCUPANCY in the same cycle.
REQ-035 A wrong-direction pulse during a grant (EXIT in GRANT_IN_S, ENTER in GRANT_OUT_S) SHALL update the count but SHALL NOT end the grant.
REQ-036 If FULL becomes true during GRANT_IN_S, the grant SHALL continue until completion or timeout.

Reset
REQ-037 While RESET is high at an edge: state IDLE, last_dir EXIT, timers 0, OCCUPANCY 0, EMPTY 1, FULL 0, GRANT_IN/GRANT_OUT/TIMEOUT_ERR/COUNT_ERR 0.
REQ-038 RESET asserted mid-grant SHALL drop the grant on the next edge and discard pending completion.
REQ-039 RESET SHALL take priority over every other input in the same cycle.

Verification (bench uses CAPACITY=3, TIMEOUT=8, CLEAR_CYCLES=2)
REQ-040 ENTER_REQ=1, ENTER pulse 3 cycles after GRANT_IN rises -> GRANT_IN high 3 cycles, OCCUPANCY 0->1, EMPTY 0, then 2 closed cycles before the next grant.
REQ-041 From reset, ENTER_REQ=EXIT_REQ=1 held, OCCUPANCY=1 -> grant sequence IN, OUT, IN, OUT, each separated by 2 closed cycles.
REQ-042 OCCUPANCY=3 with ENTER_REQ=1 and EXIT_REQ=0 -> no grant, FULL=1; then EXIT_REQ=1 -> GRANT_OUT; EXIT pulse -> OCCUPANCY=2, FULL=0.
REQ-043 GRANT_OUT with no EXIT pulse -> GRANT_OUT high 8 cycles, one TIMEOUT_ERR pulse, OCCUPANCY unchanged.
REQ-044 ENTER and EXIT in the same cycle at OCCUPANCY=2 -> OCCUPANCY stays 2, no COUNT_ERR; EXIT at OCCUPANCY=0 -> COUNT_ERR pulse, OCCUPANCY stays 0.
REQ-045 RESET for 1 cycle during GRANT_IN with OCCUPANCY=2 -> next cycle GRANT_IN=0, OCCUPANCY=0, EMPTY=1; the next tie grants IN.
